// File: rtl/enigma_core.sv
// enigma_core: three-rotor Enigma engine (I-II-III, reflector B, rings A, no plugboard).
// Two-stage pipeline. Stage 1 steps the rotors and captures the symbol together with
// its post-step positions. Stage 2 runs the full rotor path and registers the result.
module enigma_core (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  sym_i,
    input  logic        sym_val_i,
    input  logic        cfg_val_i,
    input  logic [14:0] cfg_pos_i,
    output logic [6:0]  sym_o,
    output logic        sym_val_o,
    output logic        sym_err_o,
    output logic        cfg_err_o,
    output logic [14:0] pos_o
);

    typedef logic [4:0] rom_t [0:25];

    localparam rom_t ROT_I   = '{5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21,
                                 5'd25, 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20,
                                 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
    localparam rom_t INV_I   = '{5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21,
                                 5'd25, 5'd1,  5'd4,  5'd2,  5'd10, 5'd12, 5'd19, 5'd7,  5'd23,
                                 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};
    localparam rom_t ROT_II  = '{5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23,
                                 5'd1,  5'd11, 5'd7,  5'd22, 5'd19, 5'd12, 5'd2,  5'd16, 5'd6,
                                 5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
    localparam rom_t INV_II  = '{5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,
                                 5'd1,  5'd3,  5'd10, 5'd14, 5'd19, 5'd24, 5'd20, 5'd16, 5'd6,
                                 5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};
    localparam rom_t ROT_III = '{5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17,
                                 5'd19, 5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4,  5'd8,  5'd22,
                                 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
    localparam rom_t INV_III = '{5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16,
                                 5'd4,  5'd20, 5'd5,  5'd21, 5'd13, 5'd25, 5'd7,  5'd24, 5'd8,
                                 5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};
    localparam rom_t REF_B   = '{5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15,
                                 5'd23, 5'd13, 5'd6,  5'd14, 5'd10, 5'd12, 5'd8,  5'd4,  5'd1,
                                 5'd5,  5'd25, 5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19};

    localparam logic [4:0] NOTCH_II  = 5'd4;
    localparam logic [4:0] NOTCH_III = 5'd21;

    // (a + b) mod 26 for a, b in 0..25
    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26)
            s = s - 6'd26;
        return s[4:0];
    endfunction

    // (a - b) mod 26 for a, b in 0..25; the 6-bit wrap is undone by adding 26
    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b)
            s = s + 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] a);
        return (a == 5'd25) ? 5'd0 : a + 5'd1;
    endfunction

    logic [4:0] pos_l, pos_m, pos_r;
    logic [4:0] stp_l, stp_m, stp_r;
    logic       sym_ok, accept, sym_reject, cfg_ok, cfg_bad;

    logic       s1_val, s1_err;
    logic [4:0] s1_x, s1_l, s1_m, s1_r;
    logic [4:0] cipher;

    assign pos_o = {pos_l, pos_m, pos_r};

    // Input qualification and rotor stepping (the mid==notch term gives the double step)
    always_comb begin
        sym_ok     = (sym_i >= 7'd1) && (sym_i <= 7'd26);
        accept     = sym_val_i && !cfg_val_i && sym_ok;
        sym_reject = sym_val_i && (cfg_val_i || !sym_ok);
        cfg_ok     = cfg_val_i && (cfg_pos_i[14:10] <= 5'd25) &&
                     (cfg_pos_i[9:5] <= 5'd25) && (cfg_pos_i[4:0] <= 5'd25);
        cfg_bad    = cfg_val_i && !cfg_ok;
        stp_r      = inc26(pos_r);
        stp_m      = ((pos_r == NOTCH_III) || (pos_m == NOTCH_II)) ? inc26(pos_m) : pos_m;
        stp_l      = (pos_m == NOTCH_II) ? inc26(pos_l) : pos_l;
    end

    // Rotor path for the symbol held in stage 1, using its own captured positions
    always_comb begin
        logic [4:0] t;
        t      = sub26(ROT_III[add26(s1_x, s1_r)], s1_r);
        t      = sub26(ROT_II[add26(t, s1_m)], s1_m);
        t      = sub26(ROT_I[add26(t, s1_l)], s1_l);
        t      = REF_B[t];
        t      = sub26(INV_I[add26(t, s1_l)], s1_l);
        t      = sub26(INV_II[add26(t, s1_m)], s1_m);
        cipher = sub26(INV_III[add26(t, s1_r)], s1_r);
    end

    // Position registers: a legal config load takes priority over stepping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_l <= 5'd0;
            pos_m <= 5'd0;
            pos_r <= 5'd0;
        end else if (cfg_ok) begin
            pos_l <= cfg_pos_i[14:10];
            pos_m <= cfg_pos_i[9:5];
            pos_r <= cfg_pos_i[4:0];
        end else if (accept) begin
            pos_l <= stp_l;
            pos_m <= stp_m;
            pos_r <= stp_r;
        end
    end

    // Stage 1: capture symbol, post-step positions and the reject flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_val    <= 1'b0;
            s1_err    <= 1'b0;
            s1_x      <= 5'd0;
            s1_l      <= 5'd0;
            s1_m      <= 5'd0;
            s1_r      <= 5'd0;
            cfg_err_o <= 1'b0;
        end else begin
            s1_val    <= accept;
            s1_err    <= sym_reject;
            s1_x      <= sym_i[4:0] - 5'd1;
            s1_l      <= stp_l;
            s1_m      <= stp_m;
            s1_r      <= stp_r;
            cfg_err_o <= cfg_bad;
        end
    end

    // Stage 2: registered cipher output, forced to 0 when not valid
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sym_o     <= 7'd0;
            sym_val_o <= 1'b0;
            sym_err_o <= 1'b0;
        end else begin
            sym_o     <= s1_val ? ({2'b00, cipher} + 7'd1) : 7'd0;
            sym_val_o <= s1_val;
            sym_err_o <= s1_err;
        end
    end

endmodule

// File: doc/enigma_core.md
# enigma_core

Three-rotor Enigma cipher engine that sits directly downstream of the symbol wrapper's input memory. It accepts one plaintext symbol per cycle (1..26 = A..Z), steps its rotors Enigma-style (including the middle-rotor double step), and returns the enciphered symbol two cycles later. Its outputs feed the wrapper's output memory through the encoded-symbol/valid pair.

## Interface
- No parameters. Rotor order is fixed: left=I, middle=II, right=III. Reflector is B. Ring settings are A. There is no plugboard.
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- sym_i  in  7  plaintext symbol, 1..26
- sym_val_i  in  1  sym_i valid this cycle
- cfg_val_i  in  1  load rotor start positions this cycle
- cfg_pos_i  in  15  start positions {left[14:10], mid[9:5], right[4:0]}, each 0..25
- sym_o  out  7  enciphered symbol, 1..26; 0 when not valid
- sym_val_o  out  1  sym_o valid, one-cycle pulse per accepted symbol
- sym_err_o  out  1  rejected-symbol pulse
- cfg_err_o  out  1  rejected-config pulse
- pos_o  out  15  current rotor positions, same packing as cfg_pos_i

## Operation
- Wirings, listed as outputs for inputs A..Z:
  - I: EKMFLGDQVZNTOWYHXUSPAIBRCJ, notch Q (16)
  - II: AJDKSIRUXBLHWTMCQGZNPYFVOE, notch E (4)
  - III: BDFHJLCPRTXVZNYEIWGAKMUSQO, notch V (21)
  - reflector B: YRUHQSLDPXNGOKMIEBFZCWVJAT
- Inverse tables are constant ROMs in the RTL; they are not computed at runtime.
- Accepted symbol: sym_val_i=1, 1<=sym_i<=26, and cfg_val_i=0.
- Stepping happens before enciphering, on each accepted symbol only:
  - mid_step = (right==21) or (mid==4), where the mid==4 term is the double step.
  - left_step = (mid==4).
  - The right rotor always steps.
  - Every step is +1 mod 26 (25 wraps to 0).
- Encipher path uses the post-step positions (l, m, r):
  - x = sym_i-1
  - forward through rotor at position p: f(x) = (W[(x+p) mod 26] - p) mod 26
  - order: right, middle, left, reflector, then inverse left, inverse middle, inverse right
  - sym_o = result + 1
- All mod-26 arithmetic is done in 6-bit unsigned with conditional subtract or add of 26. No divider.
- Invalid symbol (sym_val_i=1 with sym_i==0 or sym_i>26): no step, sym_val_o stays 0, and sym_err_o pulses at the cycle where the output would have appeared.
- Config:
  - cfg_val_i=1 with all three fields <=25: pos_o takes cfg_pos_i on the next edge.
  - Any field >25: positions unchanged; cfg_err_o pulses on the next cycle.
- cfg_val_i and sym_val_i in the same cycle: config wins. The symbol is dropped and sym_err_o is pulsed as for an invalid symbol.
- Symbols already in the pipeline are unaffected by a later config; they carry their own stepped positions.
- Reset:
  - positions = 0,0,0 (AAA)
  - sym_o=0, sym_val_o=0, sym_err_o=0, cfg_err_o=0
  - the pipeline is flushed, so an in-flight symbol produces no output

## Timing
- Stage 1 (edge after acceptance): position registers update and pos_o shows the new value; the symbol and post-step positions are captured.
- Stage 2 (next edge): sym_o and sym_val_o are registered.
- Latency: symbol accepted at cycle N gives sym_val_o=1 in cycle N+2, exactly one cycle wide.
- Throughput: one symbol per cycle, back-to-back, with no stall and no backpressure.
- sym_err_o aligns to N+2. cfg_err_o aligns to N+1.
- sym_o is 0 in every cycle where sym_val_o=0.
- rst_i asserted mid-stream: the outputs read 0 on the first edge where rst_i is sampled high. Symbols presented in that cycle are ignored.

## Test plan
- Reset, then sym_i=1 for 5 consecutive cycles -> sym_o = 2,4,26,7,15 (BDZGO) in cycles 3..7; pos_o ends 0,0,5.
- cfg_pos_i={0,3,20} (ADU), then 3 symbols -> pos_o reads 0,3,21 then 0,4,22 then 1,5,23 (double step).
- Reciprocity: reset, encipher 1..26, reset, feed the 26 outputs -> 1..26 returned in order; no symbol ever maps to itself.
- sym_i=0, then sym_i=27, then sym_val_i and cfg_val_i together -> three sym_err_o pulses, no sym_val_o, positions unchanged except the legal config load.
- cfg_pos_i={26,0,0} -> cfg_err_o pulse one cycle later; pos_o unchanged. Then right=25, mid=25, left=25 with one symbol -> pos_o 25,25,0 (no middle step; 25 is not a notch).
- rst_i asserted while 2 symbols are in flight -> no sym_val_o afterwards; pos_o=0.
